// File: rtl/lc3b_types.sv
// ============================================================================
// Module   : lc3b_types (package)
// Purpose  : Shared LC-3b types for the L1/L2 memory path: the word and
//            line bus widths plus the arbiter state and source encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] pmem_bus;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_SRC_I = 1'b0,
    ARB_SRC_D = 1'b1
  } arb_src_t;

endpackage

`default_nettype wire

// File: rtl/arb_grant_select.sv
// ============================================================================
// Module   : arb_grant_select
// Purpose  : Picks the icache or dcache as winner of the downstream port and
//            keeps the history that drives tie-breaking (starvation counter
//            for fixed priority, last grant for round-robin).
// Ports    : clk, rst_n        clock, async active-low reset
//            i_req_i, d_req_i  pending requests from icache / dcache
//            grant_i           a grant is being made this cycle
//            winner_o          combinational winner for the current requests
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_grant_select
  import lc3b_types::*;
#(
  parameter int ARB_MODE     = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_req_i,
  input  logic     d_req_i,
  input  logic     grant_i,
  output arb_src_t winner_o
);

  localparam int              CNT_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q;
  arb_src_t         last_grant_q;
  logic             w_at_limit;
  arb_src_t         w_tie_winner;

  assign w_at_limit = (starve_cnt_q == C_LIMIT);

  always_comb begin
    w_tie_winner = ARB_SRC_D;
    if (ARB_MODE == 1) begin
      // Round-robin: whoever did not win last time takes the tie.
      w_tie_winner = (last_grant_q == ARB_SRC_I) ? ARB_SRC_D : ARB_SRC_I;
    end else begin
      // Fixed dcache priority unless the icache has been starved long enough.
      w_tie_winner = w_at_limit ? ARB_SRC_I : ARB_SRC_D;
    end
  end

  always_comb begin
    winner_o = w_tie_winner;
    if (i_req_i && !d_req_i) begin
      winner_o = ARB_SRC_I;
    end else if (d_req_i && !i_req_i) begin
      winner_o = ARB_SRC_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      last_grant_q <= ARB_SRC_I;
    end else if (grant_i) begin
      last_grant_q <= winner_o;
      if (winner_o == ARB_SRC_I) begin
        starve_cnt_q <= '0;
      end else if (i_req_i && !w_at_limit) begin
        // Only dcache wins taken against a waiting icache count as starvation.
        starve_cnt_q <= starve_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/l1_mem_arbiter.sv
// ============================================================================
// Module   : l1_mem_arbiter
// Purpose  : Shares one line-wide downstream memory port between the L1
//            icache and dcache. One transaction at a time: arbitrate in IDLE,
//            hold the latched request in BUSY until l2_resp, then pulse the
//            winner's resp for one cycle in RESP.
// Ports    : clk, rst_n                        clock, async active-low reset
//            i_pmem_read/address               icache fill request
//            i_pmem_rdata/resp                 icache fill return
//            d_pmem_read/write/address/wdata   dcache fill / writeback request
//            d_pmem_rdata/resp                 dcache return
//            l2_read/write/address/wdata       downstream request (registered)
//            l2_rdata/resp                     downstream completion
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1_mem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH   = $bits(lc3b_word),
  parameter int LINE_WIDTH   = $bits(pmem_bus),
  parameter int ARB_MODE     = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp
);

  arb_state_t            state_q;
  arb_src_t              winner_q;
  arb_src_t              w_winner;
  logic                  w_d_req;
  logic                  w_grant;
  logic                  l2_read_q;
  logic                  l2_write_q;
  logic [ADDR_WIDTH-1:0] l2_address_q;
  logic [LINE_WIDTH-1:0] l2_wdata_q;
  logic [LINE_WIDTH-1:0] i_rdata_q;
  logic [LINE_WIDTH-1:0] d_rdata_q;
  logic                  i_resp_q;
  logic                  d_resp_q;

  assign w_d_req = d_pmem_read | d_pmem_write;
  assign w_grant = (state_q == ARB_IDLE) && (i_pmem_read || w_d_req);

  arb_grant_select #(
    .ARB_MODE    (ARB_MODE),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant_select (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req_i (i_pmem_read),
    .d_req_i (w_d_req),
    .grant_i (w_grant),
    .winner_o(w_winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      winner_q     <= ARB_SRC_I;
      l2_read_q    <= 1'b0;
      l2_write_q   <= 1'b0;
      l2_address_q <= '0;
      l2_wdata_q   <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_resp_q     <= 1'b0;
      d_resp_q     <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (w_grant) begin
            winner_q <= w_winner;
            state_q  <= ARB_BUSY;
            if (w_winner == ARB_SRC_D) begin
              l2_address_q <= d_pmem_address;
              l2_wdata_q   <= d_pmem_wdata;
              // Read and write together is illegal; the write takes precedence.
              l2_write_q   <= d_pmem_write;
              l2_read_q    <= ~d_pmem_write;
            end else begin
              l2_address_q <= i_pmem_address;
              l2_read_q    <= 1'b1;
              l2_write_q   <= 1'b0;
            end
          end
        end
        ARB_BUSY: begin
          if (l2_resp) begin
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
            state_q    <= ARB_RESP;
            if (winner_q == ARB_SRC_D) begin
              d_rdata_q <= l2_rdata;
              d_resp_q  <= 1'b1;
            end else begin
              i_rdata_q <= l2_rdata;
              i_resp_q  <= 1'b1;
            end
          end
        end
        ARB_RESP: begin
          // The served requester still shows its request here, so no grant.
          i_resp_q <= 1'b0;
          d_resp_q <= 1'b0;
          state_q  <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign l2_read      = l2_read_q;
  assign l2_write     = l2_write_q;
  assign l2_address   = l2_address_q;
  assign l2_wdata     = l2_wdata_q;
  assign i_pmem_rdata = i_rdata_q;
  assign d_pmem_rdata = d_rdata_q;
  assign i_pmem_resp  = i_resp_q;
  assign d_pmem_resp  = d_resp_q;

endmodule

`default_nettype wire

// File: tb/tb_l1_mem_arbiter.sv
// ============================================================================
// Module   : tb_l1_mem_arbiter
// Purpose  : Self-checking bench for l1_mem_arbiter. Instance 0 runs fixed
//            priority with starvation guard, instance 1 runs round-robin.
//            Expected winners, latched operands and returned lines come from
//            a transaction-level model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l1_mem_arbiter;

  localparam int AW    = 16;
  localparam int LW    = 128;
  localparam int LIMIT = 4;

  logic clk;
  logic rst_n;

  logic          ipr   [2];
  logic          dpr   [2];
  logic          dpw   [2];
  logic [AW-1:0] ia    [2];
  logic [AW-1:0] da    [2];
  logic [LW-1:0] dwd   [2];
  logic          l2rs  [2];
  logic [LW-1:0] l2rd  [2];

  logic [LW-1:0] irdo  [2];
  logic [LW-1:0] drdo  [2];
  logic          irsp  [2];
  logic          drsp  [2];
  logic          l2r   [2];
  logic          l2w   [2];
  logic [AW-1:0] l2a   [2];
  logic [LW-1:0] l2wd  [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      l1_mem_arbiter #(
        .ADDR_WIDTH  (AW),
        .LINE_WIDTH  (LW),
        .ARB_MODE    (gi),
        .STARVE_LIMIT(LIMIT)
      ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_pmem_read   (ipr[gi]),
        .i_pmem_address(ia[gi]),
        .i_pmem_rdata  (irdo[gi]),
        .i_pmem_resp   (irsp[gi]),
        .d_pmem_read   (dpr[gi]),
        .d_pmem_write  (dpw[gi]),
        .d_pmem_address(da[gi]),
        .d_pmem_wdata  (dwd[gi]),
        .d_pmem_rdata  (drdo[gi]),
        .d_pmem_resp   (drsp[gi]),
        .l2_read       (l2r[gi]),
        .l2_write      (l2w[gi]),
        .l2_address    (l2a[gi]),
        .l2_wdata      (l2wd[gi]),
        .l2_rdata      (l2rd[gi]),
        .l2_resp       (l2rs[gi])
      );
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors    = 0;
  int miscompares = 0;

  // Model state: 0 = icache, 1 = dcache.
  int            cnt_m  [2];
  int            last_m [2];
  logic [LW-1:0] irdm   [2];
  logic [LW-1:0] drdm   [2];

  task automatic chk(input string tag, input int u, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, u, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int pick(input int u, input logic i, input logic d);
    if (i && !d) return 0;
    if (d && !i) return 1;
    if (u == 0) return (cnt_m[0] == LIMIT) ? 0 : 1;
    return (last_m[1] == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      cnt_m[u]  = 0;
      last_m[u] = 0;
      irdm[u]   = '0;
      drdm[u]   = '0;
    end
  endtask

  task automatic chk_quiet(input string tag, input int u);
    chk({tag, "_l2r"}, u, LW'(l2r[u]), '0);
    chk({tag, "_l2w"}, u, LW'(l2w[u]), '0);
    chk({tag, "_irsp"}, u, LW'(irsp[u]), '0);
    chk({tag, "_drsp"}, u, LW'(drsp[u]), '0);
  endtask

  // Runs one full grant on instance u. Entered just after a rising edge with
  // that instance in IDLE and at least one request raised; returns just after
  // the edge that brings it back to IDLE.
  task automatic run_grant(input int u, input int lat, input logic [LW-1:0] rd,
                           input bit chg, input bit drop, output int w);
    logic [AW-1:0] ea;
    logic [LW-1:0] ewd;
    logic          er;
    logic          ew;
    logic          dq;
    dq = dpr[u] | dpw[u];
    w  = pick(u, ipr[u], dq);
    if (w == 1) begin
      ea = da[u]; ewd = dwd[u]; ew = dpw[u]; er = ~dpw[u];
    end else begin
      ea = ia[u]; ewd = '0; ew = 1'b0; er = 1'b1;
    end
    if (w == 0) cnt_m[u] = 0;
    else if (ipr[u] && cnt_m[u] < LIMIT) cnt_m[u]++;
    last_m[u] = w;

    @(posedge clk); #1;
    chk("grant_l2r", u, LW'(l2r[u]), LW'(er));
    chk("grant_l2w", u, LW'(l2w[u]), LW'(ew));
    chk("grant_addr", u, LW'(l2a[u]), LW'(ea));
    if (w == 1) chk("grant_wdata", u, l2wd[u], ewd);

    for (int c = 1; c < lat; c++) begin
      if (chg) begin
        ia[u]  = ia[u] + 16'h1000;
        da[u]  = da[u] + 16'h1000;
        dwd[u] = ~dwd[u];
      end
      @(posedge clk); #1;
      chk("busy_l2r", u, LW'(l2r[u]), LW'(er));
      chk("busy_l2w", u, LW'(l2w[u]), LW'(ew));
      chk("busy_addr", u, LW'(l2a[u]), LW'(ea));
      if (w == 1) chk("busy_wdata", u, l2wd[u], ewd);
      chk("busy_irsp", u, LW'(irsp[u]), '0);
      chk("busy_drsp", u, LW'(drsp[u]), '0);
    end

    l2rs[u] = 1'b1;
    l2rd[u] = rd;
    @(posedge clk); #1;
    l2rs[u] = 1'b0;
    l2rd[u] = rnd_line();
    if (w == 0) irdm[u] = rd; else drdm[u] = rd;
    chk("resp_irsp", u, LW'(irsp[u]), LW'(w == 0));
    chk("resp_drsp", u, LW'(drsp[u]), LW'(w == 1));
    chk("resp_irdata", u, irdo[u], irdm[u]);
    chk("resp_drdata", u, drdo[u], drdm[u]);
    chk("resp_l2r", u, LW'(l2r[u]), '0);
    chk("resp_l2w", u, LW'(l2w[u]), '0);

    @(posedge clk); #1;
    chk_quiet("after_resp", u);
    if (drop) begin
      if (w == 0) ipr[u] = 1'b0;
      else begin dpr[u] = 1'b0; dpw[u] = 1'b0; end
    end
  endtask

  initial begin
    int    w;
    string ord;
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      ipr[u] = 1'b0; dpr[u] = 1'b0; dpw[u] = 1'b0;
      ia[u] = '0; da[u] = '0; dwd[u] = '0;
      l2rs[u] = 1'b0; l2rd[u] = '0;
    end
    model_reset();

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int u = 0; u < 2; u++) begin
      chk_quiet("reset", u);
      chk("reset_addr", u, LW'(l2a[u]), '0);
      chk("reset_wdata", u, l2wd[u], '0);
      chk("reset_irdata", u, irdo[u], '0);
      chk("reset_drdata", u, drdo[u], '0);
    end
    @(posedge clk); #1;

    // Icache read alone.
    ipr[0] = 1'b1; ia[0] = 16'h1230;
    run_grant(0, 3, {8{16'hA5A5}}, 1'b0, 1'b1, w);
    chk("icache_only_winner", 0, LW'(w), LW'(0));

    // Dcache writeback alone.
    dpw[0] = 1'b1; da[0] = 16'h4000; dwd[0] = 128'h0123456789ABCDEF0123456789ABCDEF;
    run_grant(0, 3, rnd_line(), 1'b0, 1'b1, w);
    chk("dcache_wr_winner", 0, LW'(w), LW'(1));

    // Both reading continuously: fixed priority with starvation relief.
    ord = "DDDDIDDDDI";
    ipr[0] = 1'b1; ia[0] = 16'h1111; dpr[0] = 1'b1; da[0] = 16'h2222;
    for (int k = 0; k < ord.len(); k++) begin
      run_grant(0, 2, rnd_line(), 1'b0, 1'b0, w);
      chk("order_mode0", 0, LW'(w), LW'((ord[k] == "I") ? 0 : 1));
    end
    ipr[0] = 1'b0; dpr[0] = 1'b0;

    // Same stimulus, round-robin.
    ord = "DIDIDI";
    ipr[1] = 1'b1; ia[1] = 16'h1111; dpr[1] = 1'b1; da[1] = 16'h2222;
    for (int k = 0; k < ord.len(); k++) begin
      run_grant(1, 2, rnd_line(), 1'b0, 1'b0, w);
      chk("order_mode1", 1, LW'(w), LW'((ord[k] == "I") ? 0 : 1));
    end
    ipr[1] = 1'b0; dpr[1] = 1'b0;

    // Address moves during BUSY; latched value must hold.
    ipr[0] = 1'b1; ia[0] = 16'h1000;
    run_grant(0, 3, rnd_line(), 1'b1, 1'b1, w);
    ia[0] = 16'h1000; da[0] = '0; dwd[0] = '0;

    // Stray l2_resp while idle.
    l2rs[0] = 1'b1; l2rd[0] = rnd_line();
    @(posedge clk); #1;
    l2rs[0] = 1'b0;
    chk_quiet("spurious", 0);
    @(posedge clk); #1;
    chk_quiet("spurious_next", 0);
    chk("spurious_irdata", 0, irdo[0], irdm[0]);
    chk("spurious_drdata", 0, drdo[0], drdm[0]);

    // Random traffic; each requester holds until served.
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 20; k++) begin
        if (!ipr[u] && $urandom_range(0, 1) == 1) begin
          ipr[u] = 1'b1; ia[u] = AW'($urandom);
        end
        if (!(dpr[u] | dpw[u]) && $urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 2))
            0:       begin dpr[u] = 1'b1; dpw[u] = 1'b0; end
            1:       begin dpr[u] = 1'b0; dpw[u] = 1'b1; end
            default: begin dpr[u] = 1'b1; dpw[u] = 1'b1; end
          endcase
          da[u] = AW'($urandom); dwd[u] = rnd_line();
        end
        if (!ipr[u] && !(dpr[u] | dpw[u])) begin
          ipr[u] = 1'b1; ia[u] = AW'($urandom);
        end
        run_grant(u, $urandom_range(1, 4), rnd_line(), 1'b0, 1'b1, w);
      end
      ipr[u] = 1'b0; dpr[u] = 1'b0; dpw[u] = 1'b0;
    end

    // Reset while BUSY.
    ipr[0] = 1'b1; ia[0] = 16'h0BEE;
    @(posedge clk); #1;
    chk("pre_reset_l2r", 0, LW'(l2r[0]), LW'(1));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int u = 0; u < 2; u++) begin
      chk_quiet("async_reset", u);
      chk("async_reset_addr", u, LW'(l2a[u]), '0);
      chk("async_reset_irdata", u, irdo[u], '0);
      chk("async_reset_drdata", u, drdo[u], '0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_reset_l2r", 0, LW'(l2r[0]), '0);
    run_grant(0, 2, rnd_line(), 1'b0, 1'b1, w);
    chk("post_reset_winner", 0, LW'(w), LW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
